// File: rtl/reg_file_cfg_if.sv
// Command/response bus between the system controller and reg_file_cfg.
// master = requester side, slave = register file side.
interface reg_file_cfg_if #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 4
);
    logic             Req_Valid;
    logic             Req_Ready;
    logic [1:0]       Op;
    logic [ADDR-1:0]  Address;
    logic [WIDTH-1:0] WrData;
    logic             Unlock;
    logic [WIDTH-1:0] RdData;
    logic             RdData_VLD;
    logic             Err;

    modport master (
        output Req_Valid, Op, Address, WrData, Unlock,
        input  Req_Ready, RdData, RdData_VLD, Err
    );

    modport slave (
        input  Req_Valid, Op, Address, WrData, Unlock,
        output Req_Ready, RdData, RdData_VLD, Err
    );
endinterface

// File: rtl/reg_file_cfg.sv
// Configuration register file: read/write/set-bits/clear-bits commands over a
// valid/ready port, per-register write protection, address range checking and
// a flat export of the low CFG_REGS registers.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  S_IDLE | ready for a command; reads/writes complete in one cycle
//  S_RMW  | applying a captured set/clear mask; no command accepted
module reg_file_cfg #(
    parameter int                     WIDTH     = 8,
    parameter int                     DEPTH     = 16,
    parameter int                     ADDR      = 4,
    parameter int                     CFG_REGS  = 4,
    parameter logic [WIDTH*DEPTH-1:0] INIT      = (WIDTH*DEPTH)'(32'h0821_0000),
    parameter logic [DEPTH-1:0]       PROT_MASK = DEPTH'(4'b1100)
) (
    input  logic                      CLK,
    input  logic                      RST,
    reg_file_cfg_if.slave             bus,
    output logic [CFG_REGS*WIDTH-1:0] CFG_OUT
);

    localparam logic [1:0]    OP_READ  = 2'b00;
    localparam logic [1:0]    OP_WRITE = 2'b01;
    localparam logic [ADDR:0] DEPTH_L  = (ADDR+1)'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RMW  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [ADDR-1:0]             rmw_addr_q;
    logic [WIDTH-1:0]            rmw_mask_q;
    logic                        rmw_clr_q;
    logic [WIDTH-1:0]            rd_data_q;
    logic                        rd_vld_q;
    logic                        err_q;

    logic req_ready;
    logic accept;
    logic addr_ok;
    logic prot_hit;
    logic reject;
    logic take;
    logic take_rmw;

    // Acceptance and error qualification of the command on the bus.
    assign accept   = bus.Req_Valid & req_ready;
    assign addr_ok  = {1'b0, bus.Address} < DEPTH_L;
    assign prot_hit = PROT_MASK[bus.Address] & ~bus.Unlock;
    // Out-of-range addresses reject first, so the protection lookup only
    // matters for addresses that exist.
    assign reject   = accept & (~addr_ok | ((bus.Op != OP_READ) & prot_hit));
    assign take     = accept & ~reject;
    assign take_rmw = take & bus.Op[1];

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a passing set/clear costs one extra cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (take_rmw) state_d = S_RMW;
            S_RMW:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        req_ready = 1'b0;
        case (state_q)
            S_IDLE:  req_ready = 1'b1;
            S_RMW:   req_ready = 1'b0;
            default: req_ready = 1'b0;
        endcase
    end

    // Next register contents: RMW update or plain write (never both at once).
    always_comb begin
        mem_d = mem_q;
        if (state_q == S_RMW) begin
            if (rmw_clr_q) begin
                mem_d[rmw_addr_q] = mem_q[rmw_addr_q] & ~rmw_mask_q;
            end else begin
                mem_d[rmw_addr_q] = mem_q[rmw_addr_q] | rmw_mask_q;
            end
        end else if (take && (bus.Op == OP_WRITE)) begin
            mem_d[bus.Address] = bus.WrData;
        end
    end

    // Register storage, RMW capture and response pulses.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mem_q      <= INIT;
            rmw_addr_q <= '0;
            rmw_mask_q <= '0;
            rmw_clr_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_vld_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            rd_vld_q <= take & (bus.Op == OP_READ);
            err_q    <= reject;
            if (take && (bus.Op == OP_READ)) begin
                rd_data_q <= mem_q[bus.Address];
            end
            if (take_rmw) begin
                rmw_addr_q <= bus.Address;
                rmw_mask_q <= bus.WrData;
                rmw_clr_q  <= bus.Op[0];
            end
        end
    end

    assign bus.Req_Ready  = req_ready;
    assign bus.RdData     = rd_data_q;
    assign bus.RdData_VLD = rd_vld_q;
    assign bus.Err        = err_q;
    assign CFG_OUT        = mem_q[CFG_REGS-1:0];

endmodule

// File: tb/tb_reg_file_cfg.sv
// Directed bench for reg_file_cfg: a behavioural model of the default
// 16-register instance checked every cycle, hand-computed literal checks, and
// a DEPTH=12 instance for out-of-range address handling.
module tb_reg_file_cfg;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    reg_file_cfg_if #(.WIDTH(8), .ADDR(4)) bus_a ();
    reg_file_cfg_if #(.WIDTH(8), .ADDR(4)) bus_b ();
    logic [31:0] cfg_a, cfg_b;

    reg_file_cfg dut_a (.CLK(CLK), .RST(RST), .bus(bus_a.slave), .CFG_OUT(cfg_a));

    reg_file_cfg #(.WIDTH(8), .DEPTH(12), .ADDR(4), .CFG_REGS(4))
        dut_b (.CLK(CLK), .RST(RST), .bus(bus_b.slave), .CFG_OUT(cfg_b));

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model of dut_a ----------------
    logic [7:0] mm [16];
    logic [7:0] m_rd;
    logic       m_vld, m_err, m_busy;
    logic [3:0] p_addr;
    logic [7:0] p_mask;
    logic       p_clr;

    function automatic logic rejected(input logic [1:0] op, input logic [3:0] a, input logic u);
        // All 16 addresses exist; registers 2 and 3 need Unlock to be modified.
        return (op != 2'b00) && (a == 4'd2 || a == 4'd3) && !u;
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 16; i++) mm[i] <= 8'h00;
            mm[2]  <= 8'h21;
            mm[3]  <= 8'h08;
            m_rd   <= 8'h00;
            m_vld  <= 1'b0;
            m_err  <= 1'b0;
            m_busy <= 1'b0;
        end else begin
            m_vld <= 1'b0;
            m_err <= 1'b0;
            if (m_busy) begin
                mm[p_addr] <= p_clr ? (mm[p_addr] & ~p_mask) : (mm[p_addr] | p_mask);
                m_busy     <= 1'b0;
            end else if (bus_a.Req_Valid) begin
                if (rejected(bus_a.Op, bus_a.Address, bus_a.Unlock)) begin
                    m_err <= 1'b1;
                end else begin
                    case (bus_a.Op)
                        2'b00: begin m_rd <= mm[bus_a.Address]; m_vld <= 1'b1; end
                        2'b01: mm[bus_a.Address] <= bus_a.WrData;
                        default: begin
                            p_addr <= bus_a.Address;
                            p_mask <= bus_a.WrData;
                            p_clr  <= bus_a.Op[0];
                            m_busy <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    // Compare dut_a against the model on every cycle out of reset.
    always @(negedge CLK) begin
        if (RST) begin
            chk("model_rddata", {24'h0, bus_a.RdData}, {24'h0, m_rd});
            chk("model_vld",    {31'h0, bus_a.RdData_VLD}, {31'h0, m_vld});
            chk("model_err",    {31'h0, bus_a.Err}, {31'h0, m_err});
            chk("model_ready",  {31'h0, bus_a.Req_Ready}, {31'h0, ~m_busy});
            chk("model_cfg",    cfg_a, {mm[3], mm[2], mm[1], mm[0]});
        end
    end

    // ---------------- stimulus ----------------
    // Present a command and hold it until accepted; returns #1 after the
    // accepting edge with the number of edges spent waiting for ready.
    task automatic cmd(input bit on_b, input logic [1:0] op, input logic [3:0] a,
                       input logic [7:0] d, input logic u, output int waits);
        logic rdy;
        waits = 0;
        if (on_b) begin
            bus_b.Req_Valid = 1'b1; bus_b.Op = op; bus_b.Address = a;
            bus_b.WrData = d; bus_b.Unlock = u;
        end else begin
            bus_a.Req_Valid = 1'b1; bus_a.Op = op; bus_a.Address = a;
            bus_a.WrData = d; bus_a.Unlock = u;
        end
        forever begin
            rdy = on_b ? bus_b.Req_Ready : bus_a.Req_Ready;
            @(posedge CLK);
            #1;
            if (rdy) break;
            waits++;
            if (waits > 8) begin
                $display("FAIL accept_timeout: got ready=0 for %0d cycles expected acceptance", waits);
                total++;
                break;
            end
        end
    endtask

    task automatic idle();
        bus_a.Req_Valid = 1'b0;
        bus_b.Req_Valid = 1'b0;
    endtask

    int w;
    logic [7:0] exp_rd;
    logic [31:0] cfg_snap;

    initial begin
        bus_a.Req_Valid = 1'b0; bus_a.Op = 2'b00; bus_a.Address = '0; bus_a.WrData = '0; bus_a.Unlock = 1'b0;
        bus_b.Req_Valid = 1'b0; bus_b.Op = 2'b00; bus_b.Address = '0; bus_b.WrData = '0; bus_b.Unlock = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ready",  {31'h0, bus_a.Req_Ready}, 32'h1);
        chk("rst_vld",    {31'h0, bus_a.RdData_VLD}, 32'h0);
        chk("rst_err",    {31'h0, bus_a.Err}, 32'h0);
        chk("rst_rddata", {24'h0, bus_a.RdData}, 32'h0);
        chk("rst_cfg",    cfg_a, 32'h0821_0000);
        RST = 1'b1;
        @(posedge CLK); #1;

        // Back-to-back reads of all registers.
        for (int i = 0; i < 16; i++) begin
            cmd(1'b0, 2'b00, 4'(i), 8'h00, 1'b0, w);
            exp_rd = (i == 2) ? 8'h21 : (i == 3) ? 8'h08 : 8'h00;
            chk($sformatf("init_read_%0d", i), {24'h0, bus_a.RdData}, {24'h0, exp_rd});
            chk($sformatf("init_vld_%0d", i), {31'h0, bus_a.RdData_VLD}, 32'h1);
        end
        idle();
        @(posedge CLK); #1;
        chk("vld_drops", {31'h0, bus_a.RdData_VLD}, 32'h0);
        chk("rddata_hold", {24'h0, bus_a.RdData}, 32'h0);

        // Write then read on the next cycle.
        cmd(1'b0, 2'b01, 4'd1, 8'h5A, 1'b0, w);
        chk("wr_cfg", {24'h0, cfg_a[15:8]}, 32'h5A);
        cmd(1'b0, 2'b00, 4'd1, 8'h00, 1'b0, w);
        chk("wr_readback", {24'h0, bus_a.RdData}, 32'h5A);

        // Set 0x0F then clear 0x50 on reg1, second command held through the busy cycle.
        cmd(1'b0, 2'b10, 4'd1, 8'h0F, 1'b0, w);
        chk("set_ready_low", {31'h0, bus_a.Req_Ready}, 32'h0);
        chk("set_no_vld", {31'h0, bus_a.RdData_VLD}, 32'h0);
        cmd(1'b0, 2'b11, 4'd1, 8'h50, 1'b0, w);
        chk("clr_waits", w, 32'd1);
        chk("set_result", {24'h0, cfg_a[15:8]}, 32'h5F);
        chk("clr_ready_low", {31'h0, bus_a.Req_Ready}, 32'h0);
        idle();
        @(posedge CLK); #1;
        chk("clr_result", {24'h0, cfg_a[15:8]}, 32'h0F);
        chk("clr_ready_back", {31'h0, bus_a.Req_Ready}, 32'h1);

        // Protected register 3.
        cmd(1'b0, 2'b01, 4'd3, 8'hFF, 1'b0, w);
        chk("prot_err", {31'h0, bus_a.Err}, 32'h1);
        chk("prot_keep", {24'h0, cfg_a[31:24]}, 32'h08);
        cmd(1'b0, 2'b01, 4'd3, 8'hFF, 1'b1, w);
        chk("unlock_no_err", {31'h0, bus_a.Err}, 32'h0);
        chk("unlock_write", {24'h0, cfg_a[31:24]}, 32'hFF);
        cmd(1'b0, 2'b10, 4'd2, 8'h80, 1'b0, w);
        chk("prot_set_err", {31'h0, bus_a.Err}, 32'h1);
        chk("prot_set_ready", {31'h0, bus_a.Req_Ready}, 32'h1);
        cmd(1'b0, 2'b00, 4'd3, 8'h00, 1'b0, w);
        chk("prot_readable", {24'h0, bus_a.RdData}, 32'hFF);
        idle();

        // Out-of-range addresses on the 12-register instance.
        cmd(1'b1, 2'b00, 4'd2, 8'h00, 1'b0, w);
        chk("b_read2", {24'h0, bus_b.RdData}, 32'h21);
        cmd(1'b1, 2'b00, 4'd13, 8'h00, 1'b0, w);
        chk("b_oor_err", {31'h0, bus_b.Err}, 32'h1);
        chk("b_oor_vld", {31'h0, bus_b.RdData_VLD}, 32'h0);
        chk("b_oor_hold", {24'h0, bus_b.RdData}, 32'h21);
        cmd(1'b1, 2'b01, 4'd12, 8'hAA, 1'b1, w);
        chk("b_oor12_err", {31'h0, bus_b.Err}, 32'h1);
        cmd(1'b1, 2'b00, 4'd11, 8'h00, 1'b0, w);
        chk("b_last_err", {31'h0, bus_b.Err}, 32'h0);
        chk("b_last_vld", {31'h0, bus_b.RdData_VLD}, 32'h1);
        chk("b_last_data", {24'h0, bus_b.RdData}, 32'h00);
        idle();
        @(posedge CLK); #1;
        chk("b_err_drops", {31'h0, bus_b.Err}, 32'h0);

        // Reset during the RMW cycle of a set on reg2.
        cmd(1'b0, 2'b10, 4'd2, 8'hC0, 1'b1, w);
        idle();
        chk("rmw_busy", {31'h0, bus_a.Req_Ready}, 32'h0);
        RST = 1'b0;
        #1;
        chk("abort_ready", {31'h0, bus_a.Req_Ready}, 32'h1);
        chk("abort_reg2", {24'h0, cfg_a[23:16]}, 32'h21);
        chk("abort_cfg", cfg_a, 32'h0821_0000);
        @(negedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        cfg_snap = cfg_a;
        chk("post_rst_reg2", {24'h0, cfg_snap[23:16]}, 32'h21);
        chk("post_rst_ready", {31'h0, bus_a.Req_Ready}, 32'h1);
        chk("post_rst_err", {31'h0, bus_a.Err}, 32'h0);
        chk("post_rst_vld", {31'h0, bus_a.RdData_VLD}, 32'h0);
        chk("post_rst_rd", {24'h0, bus_a.RdData}, 32'h0);
        repeat (2) @(posedge CLK);
        #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish by 200000");
        $fatal(1);
    end

endmodule

// File: doc/reg_file_cfg.md
# reg_file_cfg

Parametrised configuration register file with a valid/ready command port, bit-set/bit-clear read-modify-write operations, per-register write protection, parameterised reset values and address-range checking. It holds operand and system-configuration registers such as UART config and clock-divider ratio. It sits between the system controller and the ALU/UART/clock-divider blocks, and exports the low CFG_REGS registers as a flat bus.

## Interface
- WIDTH, 8, register width in bits
- DEPTH, 16, number of implemented registers (DEPTH <= 2^ADDR)
- ADDR, 4, address width
- CFG_REGS, 4, registers 0..CFG_REGS-1 exported on CFG_OUT
- INIT, {reg3=8'h08, reg2=8'h21, others 0}, WIDTH*DEPTH-bit reset image; register i = INIT[i*WIDTH +: WIDTH]
- PROT_MASK, DEPTH'b1100, bit i=1 marks register i write-protected
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-low
- Req_Valid  in  1  command valid
- Req_Ready  out  1  block can accept a command this cycle
- Op  in  2  00 read, 01 write, 10 set bits (OR), 11 clear bits (AND-NOT)
- Address  in  ADDR  target register
- WrData  in  WIDTH  write data, or bit mask for set/clear
- Unlock  in  1  permits modification of protected registers, sampled at acceptance
- RdData  out  WIDTH  read data; holds last read value
- RdData_VLD  out  1  one-cycle pulse, RdData valid
- Err  out  1  one-cycle pulse, command rejected
- CFG_OUT  out  CFG_REGS*WIDTH  register i on bits [i*WIDTH +: WIDTH]

## Operation
- A command is accepted on a rising CLK edge with Req_Valid && Req_Ready. Op, Address, WrData and Unlock are sampled only then.
- FSM states:
  - IDLE: Req_Ready=1.
  - RMW: Req_Ready=0.
- Transitions:
  - IDLE to RMW on an accepted set/clear that passes checks.
  - RMW to IDLE unconditionally after one cycle.
- Read: RdData <= mem[Address], RdData_VLD pulses. Protected registers are always readable.
- Write: mem[Address] <= WrData.
- Set/clear: address and mask are captured at acceptance. In RMW, mem <= mem | mask (set) or mem & ~mask (clear). No read response.
- Error checks, evaluated at acceptance:
  - Address >= DEPTH (any op).
  - Write, set or clear to a PROT_MASK register with Unlock=0.
- On error: no register changes, RdData unchanged, RdData_VLD=0, Err pulses, FSM stays in IDLE.
- CFG_OUT is driven combinationally from the registers.

## Timing
- Reset state: all registers = INIT, RdData=0, RdData_VLD=0, Err=0, FSM=IDLE, Req_Ready=1.
- Read accepted at edge N: RdData/RdData_VLD are valid after edge N. RdData_VLD is high for exactly one cycle unless another read is accepted at N+1 (back-to-back reads give continuous VLD).
- Write accepted at edge N: register and CFG_OUT update after edge N. A read accepted at N+1 returns the new value.
- Set/clear accepted at edge N: Req_Ready=0 during cycle N+1, the register updates at edge N+1, Req_Ready=1 again after N+1. Throughput is one RMW per 2 cycles.
- Err asserts after the rejecting edge for one cycle. Back-to-back errors give continuous Err.
- Req_Valid while Req_Ready=0 is ignored. The requester must hold the command until it is accepted.
- Reset asserted mid-RMW: the operation is aborted, the register returns to INIT, the FSM goes to IDLE, and all pulses clear immediately.
- Reads and writes have no structural hazard: one command per cycle in IDLE.

## Test plan
- Reset then read all 16 registers back-to-back -> reg2=0x21, reg3=0x08, others 0x00; RdData_VLD high for 16 consecutive cycles; CFG_OUT=0x08210000.
- Write 0x5A to reg1, read reg1 on the next cycle -> RdData=0x5A one cycle after acceptance; CFG_OUT[15:8]=0x5A.
- Set mask 0x0F on reg1 (0x5A) then clear mask 0x50 -> reg1=0x5F, then 0x0F; Req_Ready low exactly one cycle after each acceptance; a Req_Valid held through the low cycle is accepted on the following edge.
- Write 0xFF to reg3 with Unlock=0 -> Err pulse, reg3 stays 0x08. Repeat with Unlock=1 -> reg3=0xFF, no Err.
- With DEPTH=12, ADDR=4, read address 13 -> Err pulse, RdData_VLD=0, RdData retains the previous value.
- Assert RST during the RMW cycle of a set on reg2 -> reg2=0x21, Req_Ready=1, no Err or RdData_VLD after release.
